// File: rtl/eth_mdio_master.sv
// MDIO (clause 22) management master.
// Serialises one 64-bit management frame per request: a 32-bit preamble,
// then ST, OP, PHYAD, REGAD, TA and 16 data bits. MDC is generated locally
// from clk_i. On reads the master releases the line for TA and data, and
// samples mdio_i on each rising MDC edge.
module eth_mdio_master #(
    parameter int CLK_DIV = 25  // clk_i cycles per MDC half-period, 2..255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [4:0]  phy_addr_i,
    input  logic [4:0]  reg_addr_i,
    input  logic [15:0] wdata_i,
    output logic        ready_o,
    output logic        done_o,
    output logic [15:0] rdata_o,
    output logic        rd_err_o,
    output logic        mdc_o,
    output logic        mdio_o,
    output logic        mdio_oe_o,
    input  logic        mdio_i
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam logic [7:0] HALF_MAX = 8'(CLK_DIV - 1);
    localparam logic [5:0] LAST_BIT = 6'd63;
    localparam logic [5:0] TA_START = 6'd46;  // first bit a read leaves undriven
    localparam logic [5:0] TA_BIT   = 6'd47;  // PHY pulls this low when present
    localparam logic [5:0] DATA_BIT = 6'd48;

    state_t      state, state_nxt;
    logic        we_q;
    logic [62:0] frame_q;    // bits 1..63 still to be sent, next one at [62]
    logic [5:0]  bit_cnt;
    logic [7:0]  half_cnt;
    logic        mdc_q, mdio_q, oe_q;
    logic [15:0] rdata_q;
    logic        rd_err_q;

    logic        accept;
    logic        half_end;
    logic        mdc_rise;
    logic        mdc_fall;
    logic        last_bit;
    logic [5:0]  bit_nxt;
    logic        drive_nxt;

    assign accept    = req_i && (state == IDLE);
    assign half_end  = (state == SHIFT) && (half_cnt == HALF_MAX);
    assign mdc_rise  = half_end && !mdc_q;
    assign mdc_fall  = half_end && mdc_q;
    assign last_bit  = (bit_cnt == LAST_BIT);
    assign bit_nxt   = bit_cnt + 6'd1;
    // Writes drive the whole frame; reads hand the line to the PHY at TA.
    assign drive_nxt = we_q || (bit_nxt < TA_START);

    // Frame bits 1..63. Bit 0 is always a preamble 1 and is emitted at
    // accept directly. The read TA/data bits are placeholders (line is
    // released there) and are kept at 1 so mdio_o idles high.
    function automatic logic [62:0] build_tail(input logic        we,
                                               input logic [4:0]  phy,
                                               input logic [4:0]  rg,
                                               input logic [15:0] wd);
        return {31'h7FFF_FFFF, 2'b01, (we ? 2'b01 : 2'b10), phy, rg,
                (we ? 2'b10 : 2'b11), (we ? wd : 16'hFFFF)};
    endfunction

    // FSM state register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_nxt;
    end

    // FSM next state: leave SHIFT only at the end of bit 63's high phase
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_i) state_nxt = SHIFT;
            SHIFT:   if (mdc_fall && last_bit) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Half-period and bit counters; both are held at 0 outside SHIFT so
    // every frame starts from a clean preamble
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            half_cnt <= 8'd0;
            bit_cnt  <= 6'd0;
        end else if (state == SHIFT) begin
            if (half_end) begin
                half_cnt <= 8'd0;
                if (mdc_q) bit_cnt <= bit_nxt;
            end else begin
                half_cnt <= half_cnt + 8'd1;
            end
        end else begin
            half_cnt <= 8'd0;
            bit_cnt  <= 6'd0;
        end
    end

    // Request capture: everything the frame needs is frozen at accept
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            we_q    <= 1'b0;
            frame_q <= '1;
        end else if (accept) begin
            we_q    <= we_i;
            frame_q <= build_tail(we_i, phy_addr_i, reg_addr_i, wdata_i);
        end else if (mdc_fall && !last_bit) begin
            frame_q <= {frame_q[61:0], 1'b1};
        end
    end

    // Line drivers: mdio/oe only move at the start of a low phase
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mdc_q  <= 1'b0;
            mdio_q <= 1'b1;
            oe_q   <= 1'b0;
        end else if (accept) begin
            mdc_q  <= 1'b0;
            mdio_q <= 1'b1;
            oe_q   <= 1'b1;
        end else if (mdc_rise) begin
            mdc_q  <= 1'b1;
        end else if (mdc_fall) begin
            mdc_q <= 1'b0;
            if (last_bit) begin
                oe_q   <= 1'b0;
                mdio_q <= 1'b1;
            end else begin
                oe_q   <= drive_nxt;
                mdio_q <= drive_nxt ? frame_q[62] : 1'b1;
            end
        end
    end

    // Read capture on rising MDC: TA bit into rd_err, data MSB first
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rdata_q  <= 16'd0;
            rd_err_q <= 1'b0;
        end else if (accept) begin
            rdata_q  <= 16'd0;
            rd_err_q <= 1'b0;
        end else if (mdc_rise && !we_q) begin
            if (bit_cnt == TA_BIT)   rd_err_q <= mdio_i;
            if (bit_cnt >= DATA_BIT) rdata_q  <= {rdata_q[14:0], mdio_i};
        end
    end

    assign ready_o   = (state == IDLE);
    assign done_o    = (state == DONE);
    assign rdata_o   = rdata_q;
    assign rd_err_o  = rd_err_q;
    assign mdc_o     = mdc_q;
    assign mdio_o    = mdio_q;
    assign mdio_oe_o = oe_q;

endmodule

// File: tb/tb_eth_mdio_master.sv
// Bench for eth_mdio_master: table of transactions against a CLK_DIV=2
// instance with a scoreboard and PHY model, plus reset/hold corner cases
// and an MDC timing check on a CLK_DIV=25 instance.
module tb_eth_mdio_master;

    localparam int DIV  = 2;
    localparam int DIV2 = 25;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // main instance (CLK_DIV=2)
    logic        rst = 1'b1;
    logic        req = 1'b0, we = 1'b0;
    logic [4:0]  phy = '0, rga = '0;
    logic [15:0] wdata = '0;
    logic        ready, done, rd_err, mdc, mdio, mdio_oe;
    logic [15:0] rdata;
    logic        mdio_in = 1'b1;

    // timing instance (CLK_DIV=25)
    logic        req2 = 1'b0, we2 = 1'b0;
    logic [4:0]  phy2 = '0, rga2 = '0;
    logic [15:0] wdata2 = '0;
    logic        ready2, done2, rd_err2, mdc2, mdio2, oe2;
    logic [15:0] rdata2;
    logic        mdio_in2 = 1'b1;

    eth_mdio_master #(.CLK_DIV(DIV)) dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we),
        .phy_addr_i(phy), .reg_addr_i(rga), .wdata_i(wdata),
        .ready_o(ready), .done_o(done), .rdata_o(rdata), .rd_err_o(rd_err),
        .mdc_o(mdc), .mdio_o(mdio), .mdio_oe_o(mdio_oe), .mdio_i(mdio_in));

    eth_mdio_master #(.CLK_DIV(DIV2)) dut25 (
        .clk_i(clk), .rst_i(rst), .req_i(req2), .we_i(we2),
        .phy_addr_i(phy2), .reg_addr_i(rga2), .wdata_i(wdata2),
        .ready_o(ready2), .done_o(done2), .rdata_o(rdata2), .rd_err_o(rd_err2),
        .mdc_o(mdc2), .mdio_o(mdio2), .mdio_oe_o(oe2), .mdio_i(mdio_in2));

    typedef struct {
        logic        we;
        logic [4:0]  phy;
        logic [4:0]  rga;
        logic [15:0] wdata;
        logic        ta;         // what the PHY model drives on bit 47
        logic [15:0] pdata;      // what the PHY model drives on bits 48..63
        logic [15:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic        we;
        logic [63:0] frame;
        logic [63:0] mask;       // bits the master must drive
        logic        ta;
        logic [15:0] pdata;
        logic [15:0] rdata;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    vec_t vecs[8];

    int n_tests = 0, n_fail = 0;
    int cyc = 0;
    int rise_cnt = 0, acc_cyc = 0, n_done = 0, n_acc = 0;
    logic [63:0] cap_mdio = '0, cap_oe = '0;
    logic prev_mdc = 1'b0, chk_after = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] make_frame(input vec_t v);
        return {32'hFFFF_FFFF, 2'b01, (v.we ? 2'b01 : 2'b10), v.phy, v.rga,
                (v.we ? 2'b10 : 2'b00), v.wdata};
    endfunction

    function automatic logic phy_bit(input exp_t e, input int idx);
        if (e.we) return 1'b1;
        if (idx == 47) return e.ta;
        if (idx >= 48 && idx <= 63) return e.pdata[63-idx];
        return 1'b1;
    endfunction

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    // main monitor: captures the serial stream, checks on done, models the PHY
    initial forever begin
        @(negedge clk);
        if (rst) begin
            prev_mdc  = 1'b0;
            chk_after = 1'b0;
        end else begin
            if (chk_after) begin
                chk("done_width", 64'(done), 64'd0);
                chk("ready_after_done", 64'(ready), 64'd1);
                chk_after = 1'b0;
            end
            if (req && ready) begin
                acc_cyc  = cyc;
                rise_cnt = 0;
                cap_mdio = '0;
                cap_oe   = '0;
                n_acc++;
            end
            if (mdc && !prev_mdc) begin
                if (rise_cnt < 64) begin
                    cap_mdio[63-rise_cnt] = mdio;
                    cap_oe[63-rise_cnt]   = mdio_oe;
                end
                rise_cnt++;
            end
            prev_mdc = mdc;
            if (done) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 64'd1, 64'd0);
                end else begin
                    cur = exp_q.pop_front();
                    chk("bit_count", 64'(rise_cnt), 64'd64);
                    chk("mdio_stream", cap_mdio & cur.mask, cur.frame & cur.mask);
                    chk("oe_stream", cap_oe, cur.mask);
                    chk("latency", 64'(cyc - acc_cyc), 64'(128*DIV + 1));
                    chk("rd_err", 64'(rd_err), 64'(cur.err));
                    if (!cur.we) chk("rdata", 64'(rdata), 64'(cur.rdata));
                    chk("mdc_in_done", 64'(mdc), 64'd0);
                    chk("oe_in_done", 64'(mdio_oe), 64'd0);
                end
                n_done++;
                chk_after = 1'b1;
            end
            if (!mdc) mdio_in = (exp_q.size() > 0) ? phy_bit(exp_q[0], rise_cnt) : 1'b1;
        end
    end

    // timing monitor for the CLK_DIV=25 instance
    int   run2 = 0, nhi2 = 0, bad_run2 = 0, bad_tr2 = 0, acc2 = 0, lat2 = 0, n_done2 = 0;
    logic busy2 = 1'b0, first2 = 1'b0;
    logic prev_mdc2 = 1'b0, prev_mdio2 = 1'b1, prev_oe2 = 1'b0;

    initial forever begin
        @(negedge clk);
        if (!rst) begin
            if (req2 && ready2) begin
                busy2 = 1'b1; run2 = 0; nhi2 = 0; bad_run2 = 0; bad_tr2 = 0;
                first2 = 1'b1; acc2 = cyc;
            end else begin
                if ((mdio2 !== prev_mdio2 || oe2 !== prev_oe2) &&
                    !(prev_mdc2 && !mdc2) && !first2) bad_tr2++;
                first2 = 1'b0;
                if (busy2) begin
                    if (mdc2 === prev_mdc2) run2++;
                    else begin
                        if (run2 != DIV2) bad_run2++;
                        if (mdc2) nhi2++;
                        run2 = 1;
                    end
                end
                if (done2 && busy2) begin
                    lat2  = cyc - acc2;
                    busy2 = 1'b0;
                    n_done2++;
                end
            end
            prev_mdc2  = mdc2;
            prev_mdio2 = mdio2;
            prev_oe2   = oe2;
        end
    end

    task automatic wait_ready();
        int b = 0;
        while (!ready && b < 2000) begin
            @(posedge clk); #1;
            b++;
        end
        if (!ready) chk("ready_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_done(input int target, input int budget);
        int b = 0;
        while (n_done < target && b < budget) begin
            @(posedge clk); #1;
            b++;
        end
        chk("done_timeout", 64'(n_done >= target), 64'd1);
    endtask

    task automatic start_txn(input vec_t v);
        exp_t e;
        wait_ready();
        we = v.we; phy = v.phy; rga = v.rga; wdata = v.wdata;
        e.we    = v.we;
        e.frame = make_frame(v);
        e.mask  = v.we ? {64{1'b1}} : {{46{1'b1}}, {18{1'b0}}};
        e.ta    = v.ta;
        e.pdata = v.pdata;
        e.rdata = v.exp_rdata;
        e.err   = v.exp_err;
        exp_q.push_back(e);
        req = 1'b1;
    endtask

    task automatic run_vec(input vec_t v);
        int base = n_done;
        start_txn(v);
        @(posedge clk); #1;
        req = 1'b0;
        // scramble fields after accept; the frame must not notice
        we = ~v.we; phy = ~v.phy; rga = ~v.rga; wdata = ~v.wdata;
        wait_done(base + 1, 128*DIV + 40);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t hv;
        int base, acc0, b;

        vecs[0] = '{we:1'b1, phy:5'h01, rga:5'h00, wdata:16'h1140, ta:1'b1, pdata:16'hFFFF, exp_rdata:16'h0000, exp_err:1'b0};
        vecs[1] = '{we:1'b0, phy:5'h03, rga:5'h02, wdata:16'h0000, ta:1'b0, pdata:16'h0141, exp_rdata:16'h0141, exp_err:1'b0};
        vecs[2] = '{we:1'b0, phy:5'h1F, rga:5'h1F, wdata:16'h0000, ta:1'b1, pdata:16'hFFFF, exp_rdata:16'hFFFF, exp_err:1'b1};
        vecs[3] = '{we:1'b1, phy:5'h1F, rga:5'h1F, wdata:16'hFFFF, ta:1'b1, pdata:16'hFFFF, exp_rdata:16'h0000, exp_err:1'b0};
        vecs[4] = '{we:1'b1, phy:5'h00, rga:5'h00, wdata:16'h0000, ta:1'b1, pdata:16'hFFFF, exp_rdata:16'h0000, exp_err:1'b0};
        vecs[5] = '{we:1'b0, phy:5'h15, rga:5'h0A, wdata:16'h0000, ta:1'b0, pdata:16'h8001, exp_rdata:16'h8001, exp_err:1'b0};
        vecs[6] = '{we:1'b0, phy:5'h0A, rga:5'h15, wdata:16'h0000, ta:1'b1, pdata:16'h1234, exp_rdata:16'h1234, exp_err:1'b1};
        vecs[7] = '{we:1'b1, phy:5'h0A, rga:5'h15, wdata:16'hA5A5, ta:1'b1, pdata:16'hFFFF, exp_rdata:16'h0000, exp_err:1'b0};

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 64'(ready), 64'd1);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_rdata", 64'(rdata), 64'd0);
        chk("rst_rd_err", 64'(rd_err), 64'd0);
        chk("rst_mdc", 64'(mdc), 64'd0);
        chk("rst_oe", 64'(mdio_oe), 64'd0);
        chk("rst_mdio", 64'(mdio), 64'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // table-driven transactions
        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i]);
            if (i == 0) chk("write_1140_literal", cap_mdio, 64'hFFFF_FFFF_5082_1140);
        end

        // req held high with fields changing every cycle: one accept only
        base = n_done;
        acc0 = n_acc;
        hv = '{we:1'b1, phy:5'h12, rga:5'h07, wdata:16'hBEEF, ta:1'b1, pdata:16'hFFFF, exp_rdata:16'h0000, exp_err:1'b0};
        start_txn(hv);
        b = 0;
        while (b < 600) begin
            @(posedge clk); #1;
            if (n_done > base) break;
            we = 1'($urandom); phy = 5'($urandom); rga = 5'($urandom); wdata = 16'($urandom);
            b++;
        end
        req = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("hold_one_accept", 64'(n_acc - acc0), 64'd1);
        chk("hold_done_count", 64'(n_done - base), 64'd1);
        chk("hold_queue_empty", 64'(exp_q.size()), 64'd0);

        // reset in bit 40 of a write aborts the frame
        hv = '{we:1'b1, phy:5'h05, rga:5'h11, wdata:16'h3C3C, ta:1'b1, pdata:16'hFFFF, exp_rdata:16'h0000, exp_err:1'b0};
        start_txn(hv);
        @(posedge clk); #1;
        req = 1'b0;
        b = 0;
        while (!(rise_cnt == 40 && !mdc) && b < 1000) begin
            @(negedge clk);
            b++;
        end
        chk("reach_bit40", 64'(rise_cnt), 64'd40);
        #2;
        rst = 1'b1;
        #1;
        chk("abort_mdc", 64'(mdc), 64'd0);
        chk("abort_oe", 64'(mdio_oe), 64'd0);
        chk("abort_ready", 64'(ready), 64'd1);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_mdio", 64'(mdio), 64'd1);
        exp_q.delete();
        base = n_done;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("no_done_after_abort", 64'(n_done - base), 64'd0);
        hv.wdata = 16'hC33C;
        run_vec(hv);

        // MDC timing on the CLK_DIV=25 instance
        we2 = 1'b1; phy2 = 5'h1B; rga2 = 5'h04; wdata2 = 16'hA5A5;
        req2 = 1'b1;
        @(posedge clk); #1;
        req2 = 1'b0;
        wdata2 = 16'h0000;
        b = 0;
        while (n_done2 == 0 && b < 4000) begin
            @(posedge clk); #1;
            b++;
        end
        chk("div25_done", 64'(n_done2), 64'd1);
        chk("div25_high_phases", 64'(nhi2), 64'd64);
        chk("div25_phase_len", 64'(bad_run2), 64'd0);
        chk("div25_mdio_edges", 64'(bad_tr2), 64'd0);
        chk("div25_latency", 64'(lat2), 64'(128*DIV2 + 1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/eth_mdio_master.md
ETH_MDIO_MASTER -- requirements
Module: eth_mdio_master

Interface
REQ-001 SHALL have parameter CLK_DIV, default 25, meaning clk_i cycles per MDC half-period (legal range 2..255).
REQ-002 SHALL have port clk_i  input  1  system clock; the block uses one clock only.
REQ-003 SHALL have port rst_i  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port req_i  input  1  transaction request.
REQ-005 SHALL have port we_i  input  1  1 = write, 0 = read; sampled with req_i.
REQ-006 SHALL have port phy_addr_i  input  5  PHY address.
REQ-007 SHALL have port reg_addr_i  input  5  register address.
REQ-008 SHALL have port wdata_i  input  16  write data.
REQ-009 SHALL have port ready_o  output  1  idle and able to accept a request.
REQ-010 SHALL have port done_o  output  1  one-cycle completion pulse, for both reads and writes.
REQ-011 SHALL have port rdata_o  output  16  read data, valid from done_o until the next accept.
REQ-012 SHALL have port rd_err_o  output  1  PHY did not drive TA low on the last read.
REQ-013 SHALL have port mdc_o  output  1  management clock.
REQ-014 SHALL have port mdio_o  output  1  MDIO output data.
REQ-015 SHALL have port mdio_oe_o  output  1  MDIO output enable, 1 = drive.
REQ-016 SHALL have port mdio_i  input  1  MDIO input, synchronised externally.

Function
REQ-017 SHALL implement FSM states IDLE, SHIFT, DONE.
REQ-018 IDLE: ready_o=1, mdc_o=0, mdio_oe_o=0, mdio_o=1.
REQ-019 Accept occurs when req_i&&ready_o: we_i/addresses/wdata_i latched, FSM->SHIFT, ready_o=0 next cycle.
REQ-020 SHIFT: frame of 64 bits with index 0..63:
- bits 0-31: preamble of 1s.
- bits 32-33: ST=01.
- bits 34-35: OP = 01 write / 10 read.
- bits 36-40: PHYAD, MSB first.
- bits 41-45: REGAD, MSB first.
- bits 46-47: TA.
- bits 48-63: data, MSB first.
REQ-021 Each bit SHALL last 2*CLK_DIV cycles: CLK_DIV cycles with mdc_o=0, then CLK_DIV cycles with mdc_o=1.
REQ-022 mdio_o/mdio_oe_o SHALL change only in the first cycle of a bit's low phase; the first bit's low phase starts the cycle after accept.
REQ-023 Write: mdio_oe_o=1 for bits 0-63; TA driven as 10; data = latched wdata_i.
REQ-024 Read: mdio_oe_o=1 for bits 0-45 and 0 for bits 46-63.
REQ-025 Read sampling: mdio_i sampled in the cycle mdc_o goes 0->1, for bit 47 (TA) and bits 48-63, shifted MSB first into rdata_o.
REQ-026 rd_err_o SHALL be set to the bit-47 sample value; it is cleared at accept; it stays 0 for writes.
REQ-027 After the high phase of bit 63, FSM->DONE for exactly one cycle:
- done_o=1.
- mdc_o=0, mdio_oe_o=0.
- next cycle IDLE, ready_o=1.
REQ-028 Total latency: accept to done_o = 128*CLK_DIV+1 cycles.
REQ-029 req_i while not ready_o SHALL be ignored, with no queuing.
REQ-030 Changes to input fields after accept SHALL have no effect.
REQ-031 Bit counter (6-bit) and half-period counter (8-bit) SHALL wrap only under FSM control, with no free-running wrap.

Reset
REQ-032 rst_i=1 SHALL immediately force:
- FSM=IDLE.
- ready_o=1, done_o=0.
- rdata_o=0, rd_err_o=0.
- mdc_o=0, mdio_oe_o=0, mdio_o=1.
- all counters 0.
REQ-033 Reset mid-transaction SHALL abort the frame with no done_o pulse; after reset release the next request starts a fresh preamble.

Verification
REQ-034 Write, CLK_DIV=2, phy=0x01, reg=0x00, wdata=0x1140 -> serial stream:
- preamble of 32 ones.
- then 01 01 00001 00000 10 0001000101000000.
- oe high throughout.
- done_o at cycle 257 after accept.
REQ-035 Read, CLK_DIV=2, phy=0x03, reg=0x02, PHY model drives TA=0 and data 0x0141 -> oe drops at bit 46, rdata_o=0x0141, rd_err_o=0, one done_o.
REQ-036 Read with mdio_i held high (no PHY) -> rdata_o=0xFFFF, rd_err_o=1, done_o asserted normally.
REQ-037 req_i held high continuously with changing fields -> only one transaction per ready_o window; the frame uses the fields captured at accept.
REQ-038 rst_i asserted at bit 40 of a write -> mdc_o=0, mdio_oe_o=0, ready_o=1 in the same cycle; no done_o; the next write frame is complete and correct.
REQ-039 Check MDC timing with CLK_DIV=25 -> mdc_o period 50 cycles at 50% duty; mdio_o transitions only coincide with mdc_o falling, or with the first low phase after accept.
